// File: rtl/axi_dram_slave.sv
// AXI4 memory responder standing in for the DRAM behind the EDH master.
// Independent read and write engines, INCR bursts, one outstanding
// transaction per direction, fixed read latency of RD_LAT idle cycles.
module axi_dram_slave #(
  parameter int          ID_WIDTH   = 4,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 128,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          DEPTH      = 4096,
  parameter int          RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   awid_s_inf,
  input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
  input  logic [2:0]            awsize_s_inf,
  input  logic [1:0]            awburst_s_inf,
  input  logic [7:0]            awlen_s_inf,
  input  logic                  awvalid_s_inf,
  output logic                  awready_s_inf,
  input  logic [DATA_WIDTH-1:0] wdata_s_inf,
  input  logic                  wlast_s_inf,
  input  logic                  wvalid_s_inf,
  output logic                  wready_s_inf,
  output logic [ID_WIDTH-1:0]   bid_s_inf,
  output logic [1:0]            bresp_s_inf,
  output logic                  bvalid_s_inf,
  input  logic                  bready_s_inf,
  input  logic [ID_WIDTH-1:0]   arid_s_inf,
  input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
  input  logic [7:0]            arlen_s_inf,
  input  logic [2:0]            arsize_s_inf,
  input  logic [1:0]            arburst_s_inf,
  input  logic                  arvalid_s_inf,
  output logic                  arready_s_inf,
  output logic [ID_WIDTH-1:0]   rid_s_inf,
  output logic [DATA_WIDTH-1:0] rdata_s_inf,
  output logic [1:0]            rresp_s_inf,
  output logic                  rlast_s_inf,
  output logic                  rvalid_s_inf,
  input  logic                  rready_s_inf
);

  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [3:0]            LAT_LAST = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

  // Byte address falls inside the DEPTH-word window starting at BASE.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE) && (((a - BASE) >> 4) < ADDR_WIDTH'(DEPTH));
  endfunction

  // Word index of a byte address; the low nibble is ignored.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE) >> 4);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write engine ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t w_state, w_state_n;

  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic                  w_legal, w_err;
  logic                  aw_fire, w_fire, w_last_beat, w_hit, w_beat_err;
  logic [IDX_W-1:0]      w_idx;

  assign aw_fire     = awvalid_s_inf & awready_s_inf;
  assign w_fire      = wvalid_s_inf & wready_s_inf;
  assign w_last_beat = (w_cnt == w_len);
  assign w_hit       = w_fire & w_legal & addr_ok(w_addr);
  assign w_idx       = word_idx(w_addr);
  assign w_beat_err  = !(w_legal && addr_ok(w_addr)) || (wlast_s_inf != w_last_beat);

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_n;
  end

  // Write FSM next state: address, data burst, then response.
  always_comb begin
    w_state_n = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_state_n = W_DATA; else w_state_n = W_IDLE;
      W_DATA:  if (w_fire && w_last_beat) w_state_n = W_RESP; else w_state_n = W_DATA;
      W_RESP:  if (bvalid_s_inf && bready_s_inf) w_state_n = W_IDLE; else w_state_n = W_RESP;
      default: w_state_n = W_IDLE;
    endcase
  end

  // Write handshake outputs, burst bookkeeping and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      awready_s_inf <= 1'b0;
      wready_s_inf  <= 1'b0;
      bvalid_s_inf  <= 1'b0;
      bid_s_inf     <= '0;
      bresp_s_inf   <= 2'b00;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= 8'd0;
      w_cnt         <= 8'd0;
      w_legal       <= 1'b0;
      w_err         <= 1'b0;
    end else begin
      awready_s_inf <= (w_state_n == W_IDLE);
      wready_s_inf  <= (w_state_n == W_DATA);
      bvalid_s_inf  <= (w_state_n == W_RESP);
      if (aw_fire) begin
        w_id    <= awid_s_inf;
        w_addr  <= awaddr_s_inf;
        w_len   <= awlen_s_inf;
        w_cnt   <= 8'd0;
        w_legal <= (awsize_s_inf == 3'b100) && (awburst_s_inf == 2'b01);
        w_err   <= 1'b0;
      end else if (w_fire) begin
        w_addr <= w_addr + ADDR_WIDTH'(16);
        w_cnt  <= w_cnt + 8'd1;
        if (w_beat_err) w_err <= 1'b1;
        if (w_last_beat) begin
          bid_s_inf   <= w_id;
          bresp_s_inf <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_hit && !rst) mem[w_idx] <= wdata_s_inf;
  end

  // ---------------- read engine ----------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  r_state_t r_state, r_state_n;

  logic [ADDR_WIDTH-1:0] r_addr, ld_addr;
  logic [7:0]            r_len, r_cnt, ld_len, ld_beat;
  logic [3:0]            r_lat;
  logic                  r_legal, ld_legal, ld_ok, ld_first, ld_next, load;
  logic                  ar_fire, r_fire, r_last_beat;
  logic [IDX_W-1:0]      ld_idx;
  logic [DATA_WIDTH-1:0] ld_data;

  assign ar_fire     = arvalid_s_inf & arready_s_inf;
  assign r_fire      = rvalid_s_inf & rready_s_inf;
  assign r_last_beat = (r_cnt == r_len);

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_n;
  end

  // Read FSM next state: accept, wait out the latency, stream beats.
  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_n = (RD_LAT == 0) ? R_DATA : R_WAIT; else r_state_n = R_IDLE;
      R_WAIT:  if (r_lat == LAT_LAST) r_state_n = R_DATA; else r_state_n = R_WAIT;
      R_DATA:  if (r_fire && r_last_beat) r_state_n = R_IDLE; else r_state_n = R_DATA;
      default: r_state_n = R_IDLE;
    endcase
  end

  // Next beat to present; a write landing on the same edge is forwarded so
  // the beat reflects memory as of the cycle it is first presented.
  always_comb begin
    ld_addr  = (r_state == R_IDLE) ? araddr_s_inf : r_addr;
    ld_legal = (r_state == R_IDLE) ? ((arsize_s_inf == 3'b100) && (arburst_s_inf == 2'b01)) : r_legal;
    ld_len   = (r_state == R_IDLE) ? arlen_s_inf : r_len;
    ld_first = (r_state != R_DATA) && (r_state_n == R_DATA);
    ld_next  = r_fire && !r_last_beat;
    load     = ld_first || ld_next;
    ld_beat  = ld_first ? 8'd0 : (r_cnt + 8'd1);
    ld_ok    = ld_legal && addr_ok(ld_addr);
    ld_idx   = word_idx(ld_addr);
    if (w_hit && (w_idx == ld_idx)) ld_data = wdata_s_inf;
    else                            ld_data = mem[ld_idx];
  end

  // Read handshake outputs and beat registers; data holds during stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      arready_s_inf <= 1'b0;
      rvalid_s_inf  <= 1'b0;
      rlast_s_inf   <= 1'b0;
      rid_s_inf     <= '0;
      rresp_s_inf   <= 2'b00;
      rdata_s_inf   <= '0;
      r_addr        <= '0;
      r_len         <= 8'd0;
      r_cnt         <= 8'd0;
      r_lat         <= 4'd0;
      r_legal       <= 1'b0;
    end else begin
      arready_s_inf <= (r_state_n == R_IDLE);
      rvalid_s_inf  <= (r_state_n == R_DATA);
      if (ar_fire) begin
        rid_s_inf <= arid_s_inf;
        r_len     <= arlen_s_inf;
        r_legal   <= ld_legal;
        r_lat     <= 4'd0;
        r_cnt     <= 8'd0;
        r_addr    <= araddr_s_inf;
      end else if (r_state == R_WAIT) begin
        r_lat <= r_lat + 4'd1;
      end else if (ld_next) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      if (load) begin
        rdata_s_inf <= ld_ok ? ld_data : '0;
        rresp_s_inf <= ld_ok ? 2'b00 : 2'b10;
        rlast_s_inf <= (ld_beat == ld_len);
        r_addr      <= ld_addr + ADDR_WIDTH'(16);
      end
    end
  end

endmodule
